// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared 640x480@60 raster constants and sync decode helpers
// Revision: 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int VGA_PIX_DIV   = 4;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Half-open window test: lo <= val < hi.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_div.sv
`default_nettype none
// ============================================================================
// pixel_tick_div : divides clk by PIX_DIV, one-clk p_tick on the last count
// Revision: 1.0
// ============================================================================
module pixel_tick_div #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int            CW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

  logic [CW-1:0] div_cnt_d;
  logic [CW-1:0] div_cnt_q;

  // With PIX_DIV=1 LAST is 0, so the counter sits at 0 and p_tick stays high.
  always_comb begin
    p_tick    = (div_cnt_q == LAST);
    div_cnt_d = (div_cnt_q >= LAST) ? '0 : div_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// vga_sync : VGA raster counters, sync/video_on decode and frame_start pulse
// Revision: 1.0
// ============================================================================
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV   = VGA_PIX_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] h_cnt_d, h_cnt_q;
  logic [9:0] v_cnt_d, v_cnt_q;
  sync_t      sync_d, sync_q;
  logic       frame_start_d, frame_start_q;
  logic       h_end, v_end;

  pixel_tick_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Using >= on the end tests folds any out-of-range count back to 0.
  always_comb begin
    h_end         = (h_cnt_q >= H_LAST);
    v_end         = (v_cnt_q >= V_LAST);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (p_tick) begin
      h_cnt_d = h_end ? '0 : h_cnt_q + 10'd1;
      if (h_end) begin
        v_cnt_d       = v_end ? '0 : v_cnt_q + 10'd1;
        frame_start_d = v_end;
      end
    end
  end

  // Decoding the next counts keeps the sync registers aligned with x/y.
  always_comb begin
    sync_d          = '0;
    sync_d.hsync    = ~in_window(h_cnt_d, HS_START, HS_END);
    sync_d.vsync    = ~in_window(v_cnt_d, VS_START, VS_END);
    sync_d.video_on = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      sync_q.hsync    <= 1'b1;
      sync_q.vsync    <= 1'b1;
      sync_q.video_on <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      sync_q          <= sync_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign video_on    = sync_q.video_on;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
// tb_vga_sync : directed self-checking bench for vga_sync (three instances)
// Revision: 1.0
// ============================================================================
module tb_vga_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic       pt_a, vo_a, hs_a, vs_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pt_b, vo_b, hs_b, vs_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       pt_c, vo_c, hs_c, vs_c, fs_c;
  logic [9:0] x_c, y_c;

  int checks = 0;
  int errors = 0;

  // Default 640x480 timing, divide-by-4 pixel clock.
  vga_sync #(.PIX_DIV(4)) dut_a (
    .clk(clk), .reset(rst_a), .p_tick(pt_a), .x(x_a), .y(y_a),
    .video_on(vo_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
  );

  // Default timing, one pixel per clock.
  vga_sync #(.PIX_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .p_tick(pt_b), .x(x_b), .y(y_b),
    .video_on(vo_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  // Miniature raster: H 8/2/3/1 (total 14), V 4/1/2/1 (total 8), 224 clks per frame.
  vga_sync #(
    .PIX_DIV(2),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_c (
    .clk(clk), .reset(rst_c), .p_tick(pt_c), .x(x_c), .y(y_c),
    .video_on(vo_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int pix, ex, ey, hs_low, fs_cnt;

    // ---------------- instance A: reset, line walk, sync window ----------------
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("a_rst_x",  32'(x_a),  0);
    chk("a_rst_y",  32'(y_a),  0);
    chk("a_rst_hs", 32'(hs_a), 1);
    chk("a_rst_vs", 32'(vs_a), 1);
    chk("a_rst_vo", 32'(vo_a), 0);
    chk("a_rst_pt", 32'(pt_a), 0);
    chk("a_rst_fs", 32'(fs_a), 0);
    rst_a = 1'b0;

    hs_low = 0;
    for (int k = 1; k <= 4401; k++) begin
      @(negedge clk);
      pix = k / 4;
      ex  = pix % 800;
      ey  = pix / 800;
      chk("a_x",  32'(x_a),  32'(ex));
      chk("a_y",  32'(y_a),  32'(ey));
      chk("a_pt", 32'(pt_a), 32'(k % 4 == 3));
      chk("a_hs", 32'(hs_a), 32'(!(ex >= 656 && ex < 752)));
      chk("a_vs", 32'(vs_a), 1);
      chk("a_vo", 32'(vo_a), 32'(ex < 640));
      chk("a_fs", 32'(fs_a), 0);
      if (ey == 0 && hs_a == 1'b0) hs_low++;
    end
    chk("a_hs_low_clks", 32'(hs_low), 384);
    chk("a_mid_x", 32'(x_a), 300);
    chk("a_mid_y", 32'(y_a), 1);

    // Asynchronous reset between edges: outputs clear before the next posedge.
    #2 rst_a = 1'b1;
    #1;
    chk("a_arst_x",  32'(x_a),  0);
    chk("a_arst_y",  32'(y_a),  0);
    chk("a_arst_hs", 32'(hs_a), 1);
    chk("a_arst_vo", 32'(vo_a), 0);
    chk("a_arst_pt", 32'(pt_a), 0);
    chk("a_arst_fs", 32'(fs_a), 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("a_rel_x",  32'(x_a),  32'(k / 4));
      chk("a_rel_y",  32'(y_a),  0);
      chk("a_rel_vo", 32'(vo_a), 1);
      chk("a_rel_fs", 32'(fs_a), 0);
    end

    // ---------------- instance B: PIX_DIV=1 ----------------
    chk("b_rst_pt", 32'(pt_b), 1);
    chk("b_rst_x",  32'(x_b),  0);
    rst_b = 1'b0;
    for (int k = 1; k <= 801; k++) begin
      @(negedge clk);
      ex = k % 800;
      ey = k / 800;
      chk("b_pt", 32'(pt_b), 1);
      chk("b_x",  32'(x_b),  32'(ex));
      chk("b_y",  32'(y_b),  32'(ey));
      chk("b_hs", 32'(hs_b), 32'(!(ex >= 656 && ex < 752)));
    end

    // ---------------- instance C: full frames, frame_start, vsync ----------------
    chk("c_rst_vs", 32'(vs_c), 1);
    chk("c_rst_fs", 32'(fs_c), 0);
    rst_c  = 1'b0;
    fs_cnt = 0;
    for (int k = 1; k <= 544; k++) begin
      @(negedge clk);
      pix = k / 2;
      ex  = pix % 14;
      ey  = (pix / 14) % 8;
      chk("c_x",  32'(x_c),  32'(ex));
      chk("c_y",  32'(y_c),  32'(ey));
      chk("c_hs", 32'(hs_c), 32'(!(ex >= 10 && ex < 13)));
      chk("c_vs", 32'(vs_c), 32'(!(ey >= 5 && ey < 7)));
      chk("c_vo", 32'(vo_c), 32'(ex < 8 && ey < 4));
      chk("c_fs", 32'(fs_c), 32'(k % 224 == 0));
      if (fs_c) fs_cnt++;
    end
    chk("c_fs_count", 32'(fs_cnt), 2);
    chk("c_mid_x", 32'(x_c), 6);
    chk("c_mid_y", 32'(y_c), 3);

    // Mid-frame asynchronous reset, then a fresh frame with no startup pulse.
    #2 rst_c = 1'b1;
    #1;
    chk("c_arst_x",  32'(x_c),  0);
    chk("c_arst_y",  32'(y_c),  0);
    chk("c_arst_vs", 32'(vs_c), 1);
    chk("c_arst_vo", 32'(vo_c), 0);
    chk("c_arst_pt", 32'(pt_c), 0);
    repeat (2) @(negedge clk);
    rst_c  = 1'b0;
    fs_cnt = 0;
    for (int k = 1; k <= 230; k++) begin
      @(negedge clk);
      pix = k / 2;
      chk("c_rel_x",  32'(x_c),  32'(pix % 14));
      chk("c_rel_y",  32'(y_c),  32'((pix / 14) % 8));
      chk("c_rel_fs", 32'(fs_c), 32'(k == 224));
      if (fs_c) fs_cnt++;
    end
    chk("c_rel_fs_count", 32'(fs_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Generates the VGA raster that the pixel generator consumes: pixel tick, x/y scan coordinates, video_on, and active-low hsync/vsync.
- Also emits a one-clock frame_start pulse, used by the ball and paddle logic to step game state once per frame.
- Sits between the board clock and pixel_gen / the VGA connector.
- Default timing is 640x480 @ 60 Hz, with the 100 MHz system clock divided by 4 to give the pixel rate.

Parameters:
- PIX_DIV, 4, system clocks per pixel (>=1)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- p_tick  out  1  one-clk pixel-enable pulse, every PIX_DIV clocks
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  high while x<H_DISPLAY and y<V_DISPLAY
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-clk pulse when the raster wraps to (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_*, 800 by default.
  - V_TOTAL = sum of V_*, 525 by default.
  - Both must fit in 10 bits.
- Divider:
  - div_cnt counts 0..PIX_DIV-1 and wraps; it increments every clk.
  - p_tick = (div_cnt == PIX_DIV-1), decoded combinationally from the register.
  - With PIX_DIV=1, p_tick is constantly 1.
- Horizontal counter:
  - h_cnt advances only on an edge where p_tick=1.
  - It wraps H_TOTAL-1 -> 0.
- Vertical counter:
  - v_cnt advances only on an edge where p_tick=1 and h_cnt==H_TOTAL-1.
  - It wraps V_TOTAL-1 -> 0.
  - Simultaneous wrap at (799,524) goes to (0,0) in one edge.
- x = h_cnt, y = v_cnt, both registered outputs.
- hsync, vsync, video_on are registers loaded from decodes of the next count values. They are therefore cycle-aligned with x/y: zero latency relative to the coordinates.
- Decode rules:
  - hsync = 0 iff H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- frame_start:
  - Registered; high for exactly one clk, the clk in which x/y first read (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - It does not fire on release from reset.
- Reset (async, immediate):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - hsync=1, vsync=1, video_on=0, frame_start=0.
  - p_tick=0 when PIX_DIV>1.
- After reset deasserts:
  - The first clk edge loads video_on=1; the count is still (0,0).
  - The first p_tick occurs on the PIX_DIV-th clk after release.
- Reset asserted mid-line or mid-frame returns all state to the reset values on that event, with no partial-line completion.
- Counters never exceed TOTAL-1. An unreachable count (e.g. via upset) wraps to 0 on the next advance.

Decomposition:
- vga_timing_pkg holds the 640x480@60 constants (display, porch and sync values, H_TOTAL/V_TOTAL), so pixel_gen margins and wall/paddle geometry share one source.
- One sub-module, pixel_tick_div: parameterised divider producing p_tick, clk/reset only.
- The h/v counters and sync decode stay in vga_sync.

Test Plan:
- Reset held 5 clks, then released -> during reset hsync=vsync=1, video_on=0, x=y=0; first p_tick at clk 4 after release; x=1 after that edge.
- Run one full line -> p_tick period 4 clks; x 0..799 then 0; y increments only at the 799->0 wrap; 3200 clks per line.
- Horizontal sync window -> hsync low exactly for x=656..751 (96 pixels, 384 clks), high at x=655 and x=752; video_on falls at x=640.
- Full frame -> vsync low only for y=490..491; video_on=0 for all y>=480; frame_start single 1-clk pulse every 1,680,000 clks, coincident with x=y=0.
- Async reset asserted at x=300, y=200 between clock edges -> outputs go to reset values without waiting for clk; after release, timing restarts from (0,0) with no frame_start.
- PIX_DIV=1 instance -> p_tick constantly 1; x advances every clk; line length 800 clks.
